argmax_seq_ctrl: RTL

//  Sequential controller that computes max/argmax over a frame of N scores using one compare-and-select step per cycle.

---
 rtl/argmax_seq_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/argmax_seq_ctrl.sv
// Serial max/argmax over a frame of N_INPUTS unsigned scores; one compare-and-select per accepted beat.
// Latency: out_valid rises the cycle after the last beat is accepted; frame period is at least N_INPUTS+1 cycles.
// Backpressure: in_ready drops while a result waits in DONE; the result is held until out_ready. ARGMAX_MAXVAL_OUT_EN adds out_value.
module argmax_seq_ctrl #(
  parameter int N_INPUTS = 26,
  parameter int VAL_W    = 8,
  parameter int LBL_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VAL_W-1:0] in_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LBL_W-1:0] out_label,
`ifdef ARGMAX_MAXVAL_OUT_EN
  output logic [VAL_W-1:0] out_value,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [LBL_W-1:0] LAST_LBL = LBL_W'(N_INPUTS - 1);

  state_t           state;
  logic [LBL_W-1:0] count;
  logic [VAL_W-1:0] best_val;
  logic [LBL_W-1:0] best_lbl;

  logic beat;
  logic take;

  assign beat = in_valid & in_ready;
  assign take = out_valid & out_ready;

  // in_ready/busy/out_valid are registered copies of the next state so every output is 0 in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      best_val  <= '0;
      best_lbl  <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (abort) begin
      state     <= IDLE;
      count     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (beat) begin
            best_val <= in_value;
            best_lbl <= '0;
            count    <= LBL_W'(1);
            if (N_INPUTS == 1) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              state <= ACCUM;
              busy  <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (beat) begin
            // Strict compare keeps the earlier label on ties.
            if (in_value > best_val) begin
              best_val <= in_value;
              best_lbl <= count;
            end
            count <= count + LBL_W'(1);
            if (count == LAST_LBL) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              busy      <= 1'b0;
            end
          end
        end
        DONE: begin
          if (take) begin
            state     <= IDLE;
            count     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          count     <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign out_label = best_lbl;
`ifdef ARGMAX_MAXVAL_OUT_EN
  assign out_value = best_val;
`endif

endmodule
